// File: rtl/mm_job_scheduler_if.sv
// Bus bundle for mm_job_scheduler: requester port, multiplier port and response port.
//   slave  : scheduler side (drives in_ready, mul_*, res_*, busy)
//   master : environment side (requesters, multiplier, result consumer)
interface mm_job_scheduler_if #(
    parameter int unsigned DIM   = 16,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NREQ  = 2
);
    localparam int unsigned OPW = DIM * DIM * WIDTH;
    localparam int unsigned RW  = DIM * DIM * 2 * WIDTH;
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]      in_valid;
    logic [NREQ-1:0]      in_ready;
    logic [NREQ*OPW-1:0]  in0;
    logic [NREQ*OPW-1:0]  in1;
    logic                 mul_reset_n;
    logic [OPW-1:0]       mul_in0;
    logic [OPW-1:0]       mul_in1;
    logic [RW-1:0]        mul_out;
    logic                 mul_finished;
    logic                 res_valid;
    logic                 res_ready;
    logic [IDW-1:0]       res_id;
    logic [RW-1:0]        res_data;
    logic                 res_timeout;
    logic                 busy;

    modport slave (
        input  in_valid, in0, in1, mul_out, mul_finished, res_ready,
        output in_ready, mul_reset_n, mul_in0, mul_in1,
               res_valid, res_id, res_data, res_timeout, busy
    );

    modport master (
        output in_valid, in0, in1, mul_out, mul_finished, res_ready,
        input  in_ready, mul_reset_n, mul_in0, mul_in1,
               res_valid, res_id, res_data, res_timeout, busy
    );
endinterface

// File: rtl/mm_job_scheduler.sv
// Shares one unary-stream matrix multiplier between NREQ requesters.
// A round-robin arbiter grants one job, its operands are registered, the
// multiplier is cleared and run until mul_finished (or TIMEOUT), and the
// product is returned on a valid/ready response port tagged with the id.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : mm_job_scheduler_if.slave
//                in_valid/in_ready/in0/in1          job request per requester
//                mul_reset_n/mul_in0/mul_in1         multiplier control/operands
//                mul_out/mul_finished                multiplier result/completion
//                res_valid/res_ready/res_id/res_data/res_timeout  response
//                busy                                scheduler not idle
module mm_job_scheduler #(
    parameter int unsigned DIM        = 16,
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned NREQ       = 2,
    parameter int unsigned CLR_CYCLES = 1,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic clk,
    input  logic reset,
    mm_job_scheduler_if.slave bus
);
    localparam int unsigned OPW  = DIM * DIM * WIDTH;
    localparam int unsigned RW   = DIM * DIM * 2 * WIDTH;
    localparam int unsigned IDW  = $clog2(NREQ);
    localparam int unsigned TMAX = (TIMEOUT > CLR_CYCLES) ? TIMEOUT : CLR_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t          state, state_next;
    logic [TW-1:0]   timer, timer_next;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  job_id;
    logic [IDW-1:0]  grant, cand;
    logic            grant_found;
    logic [NREQ-1:0] ready_vec;
    logic            accept, run_done, run_timeout, capture, resp_done;

    logic [OPW-1:0]  mul_in0_q, mul_in1_q;
    logic [RW-1:0]   res_data_q;
    logic [IDW-1:0]  res_id_q;
    logic            res_timeout_q, res_valid_q, mul_reset_n_q, busy_q;

    // Round-robin arbiter: first valid requester at or after rr_ptr.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        cand        = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(rr_ptr) + k) % NREQ);
            if (!grant_found && bus.in_valid[cand]) begin
                grant       = cand;
                grant_found = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        state_next  = state;
        timer_next  = timer;
        ready_vec   = '0;
        accept      = 1'b0;
        run_done    = 1'b0;
        run_timeout = 1'b0;
        capture     = 1'b0;
        resp_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_found) begin
                    ready_vec[grant] = 1'b1;
                    accept           = 1'b1;
                    timer_next       = '0;
                    state_next       = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (timer == TW'(CLR_CYCLES - 1)) begin
                    timer_next = '0;
                    state_next = S_RUN;
                end else begin
                    timer_next = timer + TW'(1);
                end
            end
            S_RUN: begin
                timer_next = timer + TW'(1);
                // First RUN cycle: multiplier count is still zero, flag is stale.
                if (bus.mul_finished && (timer != '0)) begin
                    run_done   = 1'b1;
                    state_next = S_DRAIN;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    run_done    = 1'b1;
                    run_timeout = 1'b1;
                    state_next  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                capture    = 1'b1;
                state_next = S_RESP;
            end
            S_RESP: begin
                if (bus.res_ready) begin
                    resp_done  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand/result datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_in0_q     <= '0;
            mul_in1_q     <= '0;
            job_id        <= '0;
            rr_ptr        <= '0;
            res_data_q    <= '0;
            res_id_q      <= '0;
            res_timeout_q <= 1'b0;
            res_valid_q   <= 1'b0;
            mul_reset_n_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            if (accept) begin
                mul_in0_q <= bus.in0[32'(grant) * OPW +: OPW];
                mul_in1_q <= bus.in1[32'(grant) * OPW +: OPW];
                job_id    <= grant;
            end
            if (run_done) begin
                res_timeout_q <= run_timeout;
            end
            if (capture) begin
                res_data_q <= bus.mul_out;
                res_id_q   <= job_id;
            end
            if (resp_done) begin
                rr_ptr <= IDW'((32'(job_id) + 32'd1) % NREQ);
            end
            // Multiplier only released while running or draining.
            mul_reset_n_q <= (state_next == S_RUN) || (state_next == S_DRAIN);
            res_valid_q   <= (state_next == S_RESP);
            busy_q        <= (state_next != S_IDLE);
        end
    end

    // Grant is combinational so a request can be taken in its first IDLE cycle.
    assign bus.in_ready    = reset ? '0 : ready_vec;
    assign bus.mul_reset_n = mul_reset_n_q;
    assign bus.mul_in0     = mul_in0_q;
    assign bus.mul_in1     = mul_in1_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_id      = res_id_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_timeout = res_timeout_q;
    assign bus.busy        = busy_q;
endmodule
